// File: rtl/clz_pkg.sv
// Shared types and helpers for the pipelined leading/trailing run counter.
// clz_prep folds every mode onto a plain leading-zero search.
package clz_pkg;

    typedef enum logic [1:0] {
        CLZ_LZ = 2'b00,
        CLZ_LO = 2'b01,
        CLZ_TZ = 2'b10,
        CLZ_TO = 2'b11
    } clz_mode_e;

    // Upper bound on W_IN accepted by clz_prep.
    localparam int CLZ_MAX_W = 512;

    function automatic int clz_n_seg(input int w_in, input int chunk);
        return (w_in + chunk - 1) / chunk;
    endfunction

    function automatic int clz_w_pad(input int w_in, input int chunk);
        return clz_n_seg(w_in, chunk) * chunk;
    endfunction

    // Operates on the low w bits. Ones-runs invert, trailing runs bit-reverse.
    function automatic logic [CLZ_MAX_W-1:0] clz_prep(input logic [CLZ_MAX_W-1:0] d,
                                                      input int w, input clz_mode_e m);
        logic [CLZ_MAX_W-1:0] x;
        logic [CLZ_MAX_W-1:0] r;
        x = (m == CLZ_LO || m == CLZ_TO) ? ~d : d;
        r = x;
        if (m == CLZ_TZ || m == CLZ_TO) begin
            r = '0;
            for (int i = 0; i < CLZ_MAX_W; i++) begin
                if (i < w) r[i] = x[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/clz_pipe_chunk.sv
// Combinational leading-zero count of one CHUNK-bit segment plus all-zero flag.
// o_lcnt is only meaningful when o_zero is low.
module clz_chunk #(
    parameter int CHUNK  = 8,
    parameter int W_LCNT = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0]  i_data,
    output logic [W_LCNT-1:0] o_lcnt,
    output logic              o_zero
);
    int   w_n;
    logic w_found;

    always_comb begin
        w_n     = 0;
        w_found = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (!w_found) begin
                if (i_data[CHUNK-1-i]) w_found = 1'b1;
                else                   w_n = w_n + 1;
            end
        end
        o_zero = ~w_found;
        o_lcnt = w_found ? W_LCNT'(w_n) : '0;
    end
endmodule

// File: rtl/clz_pipe.sv
// Two-stage valid/ready leading/trailing zero/one counter with normalised output.
// S1 registers per-segment counts; S2 priority-selects, barrel-shifts and registers.
module clz_pipe
    import clz_pkg::*;
#(
    parameter int W_IN  = 32,
    parameter int CHUNK = 8,
    parameter int W_TAG = 4,
    parameter int W_CNT = $clog2(W_IN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN-1:0]   in_data,
    input  logic [1:0]        in_mode,
    input  logic [W_TAG-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_CNT-1:0]  out_count,
    output logic              out_all,
    output logic [W_IN-1:0]   out_norm,
    output logic [W_TAG-1:0]  out_tag
);
    localparam int N_SEG  = clz_n_seg(W_IN, CHUNK);
    localparam int W_PAD  = clz_w_pad(W_IN, CHUNK);
    localparam int W_LCNT = $clog2(CHUNK);

    // Handshake: a beat moves on a port at a rising edge where valid && ready.
    // A stage loads when empty or when its occupant moves on the same edge;
    // out_ready reaches in_ready combinationally through these terms.
    logic w_s2_load;
    logic w_s1_load;
    logic w_s1_take;

    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign w_s1_take = w_s1_load & in_valid;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;

    logic [CLZ_MAX_W-1:0] w_prep_ext;
    logic [W_PAD-1:0]     w_padded;
    logic [W_LCNT-1:0]    w_lcnt [N_SEG];
    logic [N_SEG-1:0]     w_zero;

    assign w_prep_ext = clz_prep(CLZ_MAX_W'(in_data), W_IN, clz_mode_e'(in_mode));

    // Ones below the LSB stop the search, capping the count at W_IN.
    always_comb begin
        w_padded = '1;
        w_padded[W_PAD-1 -: W_IN] = w_prep_ext[W_IN-1:0];
    end

    for (genvar g = 0; g < N_SEG; g++) begin : g_seg
        clz_chunk #(.CHUNK(CHUNK), .W_LCNT(W_LCNT)) u_chunk (
            .i_data (w_padded[W_PAD-1-g*CHUNK -: CHUNK]),
            .o_lcnt (w_lcnt[g]),
            .o_zero (w_zero[g])
        );
    end

    logic [W_LCNT-1:0] r_s1_lcnt [N_SEG];
    logic [N_SEG-1:0]  r_s1_zero;
    logic [W_IN-1:0]   r_s1_data;
    clz_mode_e         r_s1_mode;
    logic [W_TAG-1:0]  r_s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= '0;
            r_s1_data  <= '0;
            r_s1_mode  <= CLZ_LZ;
            r_s1_tag   <= '0;
            for (int g = 0; g < N_SEG; g++) r_s1_lcnt[g] <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (w_s1_take) begin
                r_s1_zero <= w_zero;
                r_s1_data <= in_data;
                r_s1_mode <= clz_mode_e'(in_mode);
                r_s1_tag  <= in_tag;
                for (int g = 0; g < N_SEG; g++) r_s1_lcnt[g] <= w_lcnt[g];
            end
        end
    end

    int               w_n;
    logic             w_found;
    logic [W_CNT-1:0] w_cnt;
    logic [W_IN-1:0]  w_norm;

    always_comb begin
        w_n     = W_IN;
        w_found = 1'b0;
        for (int g = 0; g < N_SEG; g++) begin
            if (!w_found && !r_s1_zero[g]) begin
                w_found = 1'b1;
                w_n     = g * CHUNK + int'(r_s1_lcnt[g]);
            end
        end
        w_cnt  = W_CNT'(w_n);
        w_norm = r_s1_mode[1] ? (r_s1_data >> w_cnt) : (r_s1_data << w_cnt);
    end

    logic [W_CNT-1:0] r_out_count;
    logic             r_out_all;
    logic [W_IN-1:0]  r_out_norm;
    logic [W_TAG-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_out_count <= '0;
            r_out_all   <= 1'b0;
            r_out_norm  <= '0;
            r_out_tag   <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_count <= w_cnt;
                r_out_all   <= (w_n == W_IN);
                r_out_norm  <= w_norm;
                r_out_tag   <= r_s1_tag;
            end
        end
    end

    assign out_count = r_out_count;
    assign out_all   = r_out_all;
    assign out_norm  = r_out_norm;
    assign out_tag   = r_out_tag;
endmodule

// File: tb/tb_clz_pipe.sv
// Bench for clz_pipe: a 32/8 instance and a 20/8 instance checked against a
// bit-walking reference model through per-instance expected queues.
module tb_clz_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_all;
  logic [31:0] a_in_data, a_out_norm;
  logic [1:0]  a_in_mode;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [5:0]  a_out_count;

  // 20-bit instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_all;
  logic [19:0] b_in_data, b_out_norm;
  logic [1:0]  b_in_mode;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [4:0]  b_out_count;

  clz_pipe #(.W_IN(32), .CHUNK(8), .W_TAG(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_all(a_out_all), .out_norm(a_out_norm), .out_tag(a_out_tag)
  );

  clz_pipe #(.W_IN(20), .CHUNK(8), .W_TAG(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_all(b_out_all), .out_norm(b_out_norm), .out_tag(b_out_tag)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  // expected entry: [31:0] norm, [39:32] count, [40] all, [51:48] tag
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: walk from the scan end counting bits equal to the run value
  function automatic int ref_count(input logic [63:0] d, input logic [1:0] m, input int w);
    int n = 0;
    if (!m[1]) begin
      for (int i = w - 1; i >= 0; i--) begin
        if (d[i] !== m[0]) break;
        n++;
      end
    end else begin
      for (int i = 0; i < w; i++) begin
        if (d[i] !== m[0]) break;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] ref_entry(input logic [63:0] d_in, input logic [1:0] m,
                                            input logic [3:0] t, input int w);
    logic [63:0] mask, d, norm, e;
    int n;
    mask = (64'h1 << w) - 64'h1;
    d    = d_in & mask;
    n    = ref_count(d, m, w);
    norm = m[1] ? (d >> n) : ((d << n) & mask);
    e          = '0;
    e[31:0]    = norm[31:0];
    e[39:32]   = 8'(n);
    e[40]      = (n == w);
    e[51:48]   = t;
    return e;
  endfunction

  task automatic send(input bit sel, input logic [31:0] d, input logic [1:0] m, input logic [3:0] t);
    bit acc = 1'b0;
    int guard = 0;
    if (!sel) begin
      a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_in_tag = t;
    end else begin
      b_in_valid = 1'b1; b_in_data = d[19:0]; b_in_mode = m; b_in_tag = t;
    end
    do begin
      @(negedge clk); #4;
      acc = sel ? b_in_ready : a_in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 200);
    if (acc) begin
      n_acc++;
      if (!sel) exp_a.push_back(ref_entry({32'h0, d}, m, t, 32));
      else      exp_b.push_back(ref_entry({32'h0, d}, m, t, 20));
    end else begin
      check("send_timeout", {63'h0, acc}, 64'h1);
    end
    if (!sel) a_in_valid = 1'b0;
    else      b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", 64'(exp_a.size() + exp_b.size()), 64'h0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    d = $urandom;
    case ($urandom_range(0, 5))
      0: d = d >> $urandom_range(0, 31);
      1: d = d << $urandom_range(0, 31);
      2: d = ~(d >> $urandom_range(0, 31));
      3: d = ~(d << $urandom_range(0, 31));
      4: d = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
      default: ;
    endcase
    return d;
  endfunction

  always @(negedge clk) begin : mon_a
    logic [63:0] e;
    if (!rst && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected", {63'h0, a_out_valid}, 64'h0);
      end else begin
        e = exp_a.pop_front();
        check("a_count", 64'(a_out_count), 64'(e[39:32]));
        check("a_all",   64'(a_out_all),   64'(e[40]));
        check("a_norm",  64'(a_out_norm),  64'(e[31:0]));
        check("a_tag",   64'(a_out_tag),   64'(e[51:48]));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [63:0] e;
    if (!rst && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected", {63'h0, b_out_valid}, 64'h0);
      end else begin
        e = exp_b.pop_front();
        check("b_count", 64'(b_out_count), 64'(e[39:32]));
        check("b_all",   64'(b_out_all),   64'(e[40]));
        check("b_norm",  64'(b_out_norm),  64'(e[19:0]));
        check("b_tag",   64'(b_out_tag),   64'(e[51:48]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0] snap;
    bit          rnd_done;

    // clock/reset
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(a_out_valid), 64'h0);
    check("rst_out_count", 64'(a_out_count), 64'h0);
    check("rst_out_all",   64'(a_out_all),   64'h0);
    check("rst_out_norm",  64'(a_out_norm),  64'h0);
    check("rst_out_tag",   64'(a_out_tag),   64'h0);
    check("rst_in_ready",  64'(a_in_ready),  64'h1);
    @(posedge clk); #1;

    // latency: registered twice, visible after the edge following the accept
    send(1'b0, 32'h0001_0000, 2'b00, 4'h1);
    @(negedge clk);
    check("lat_s1_only", 64'(a_out_valid), 64'h0);
    @(negedge clk);
    check("lat_out", 64'(a_out_valid), 64'h1);
    check("lat_count", 64'(a_out_count), 64'd15);
    check("lat_norm", 64'(a_out_norm), 64'h8000_0000);
    @(posedge clk); #1;

    // directed corner words and each mode
    send(1'b0, 32'h0000_0000, 2'b00, 4'h2);
    send(1'b0, 32'hFFFF_FFFF, 2'b01, 4'h3);
    send(1'b0, 32'hFFF0_0000, 2'b01, 4'h4);
    send(1'b0, 32'h0000_0100, 2'b10, 4'h5);
    send(1'b0, 32'h0000_0007, 2'b11, 4'h6);
    send(1'b0, 32'h0000_0000, 2'b10, 4'h7);
    send(1'b0, 32'h8000_0001, 2'b00, 4'h8);
    drain();

    // back-pressure: 6 tagged beats, output stalled for 5 cycles
    a_out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int t = 0; t < 6; t++) send(1'b0, rand_word(), 2'($urandom_range(0, 3)), 4'(t));
      end
      begin
        repeat (3) @(negedge clk);
        snap = {a_out_valid, a_out_tag, a_out_all, a_out_count, a_out_norm};
        check("bp_full", 64'(a_out_valid), 64'h1);
        repeat (2) begin
          @(negedge clk);
          check("bp_hold", 64'({a_out_valid, a_out_tag, a_out_all, a_out_count, a_out_norm}), 64'(snap));
        end
        check("bp_in_ready", 64'(a_in_ready), 64'h0);
        check("bp_accepts", 64'(n_acc), 64'd2);
        @(posedge clk); #1 a_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("bp_stream", 64'(a_out_valid), 64'h1);
        end
      end
    join
    drain();

    // non-multiple width instance
    send(1'b1, 32'h0000_0001, 2'b00, 4'h1);
    send(1'b1, 32'h0000_0000, 2'b00, 4'h2);
    send(1'b1, 32'h0008_0000, 2'b10, 4'h3);
    send(1'b1, 32'h000F_FFFF, 2'b01, 4'h4);
    send(1'b1, 32'h000F_FFFF, 2'b11, 4'h5);
    for (int i = 0; i < 60; i++)
      send(1'b1, rand_word(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    drain();

    // randomized traffic with random gaps and random stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(1'b0, rand_word(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
          repeat ($urandom_range(0, 1) * $urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_out_ready = 1'b1;
    drain();

    // reset with two beats in flight
    a_out_ready = 1'b0;
    send(1'b0, 32'h0000_00F0, 2'b00, 4'hA);
    send(1'b0, 32'h0F00_0000, 2'b10, 4'hB);
    rst = 1'b1;
    exp_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(a_out_valid), 64'h0);
    check("rst_mid_in_ready", 64'(a_in_ready), 64'h1);
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 64'(a_out_valid), 64'h0);
    end
    @(posedge clk); #1;
    send(1'b0, 32'h0000_0400, 2'b10, 4'hC);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
